reg_alu_sequencer: RTL and testbench

//  Multi-cycle execute/writeback sequencer sitting directly downstream of gpreg.

---
 rtl/reg_alu_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_reg_alu_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_alu_sequencer.sv
// -----------------------------------------------------------------------------
// reg_alu_sequencer
//   Multi-cycle execute/writeback sequencer placed directly downstream of the
//   gpreg register file. One decoded instruction is accepted in IDLE. Its two
//   source operands are read from gpreg in READ and an 8-bit ALU result is
//   computed in EXEC. The result is written back to gpreg in WRITE.
//   gpreg writes to whatever register rA addresses, so reg_a_addr is shared in
//   time: it carries the source address in READ and the destination in WRITE.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high
//   instr_valid  in   1       instruction present on opcode/rd/rs1/rs2/imm
//   instr_ready  out  1       sequencer can accept an instruction (IDLE)
//   opcode       in   3       ALU operation
//   rd           in   ADDR_W  destination register
//   rs1, rs2     in   ADDR_W  source registers
//   imm          in   DATA_W  immediate operand
//   reg_a_addr   out  ADDR_W  gpreg rA (read port A / write address)
//   reg_b_addr   out  ADDR_W  gpreg rB
//   reg_a_data   in   DATA_W  gpreg outA (combinational read)
//   reg_b_data   in   DATA_W  gpreg outB
//   reg_wdata    out  DATA_W  gpreg data_in
//   reg_we       out  1       gpreg we
//   result       out  DATA_W  last computed result (held until next EXEC)
//   zero_flag    out  1       result == 0
//   carry_flag   out  1       carry (ADD/ADDI) or borrow (SUB/CMP), else 0
//   done         out  1       one-cycle pulse while the instruction retires
//   busy         out  1       sequencer not in IDLE
// -----------------------------------------------------------------------------
module reg_alu_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [DATA_W-1:0] imm,
   output logic [ADDR_W-1:0] reg_a_addr,
   output logic [ADDR_W-1:0] reg_b_addr,
   input  logic [DATA_W-1:0] reg_a_data,
   input  logic [DATA_W-1:0] reg_b_data,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic [DATA_W-1:0] result,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic              done,
   output logic              busy
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_MOVI = 3'd5;
   localparam logic [2:0] OP_ADDI = 3'd6;
   localparam logic [2:0] OP_CMP  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   // ALU with one extra bit: bit DATA_W is the carry for additions and the
   // borrow for subtractions (a 9-bit unsigned difference sets its top bit
   // exactly when a < b). Logical ops and MOVI leave it cleared.
   function automatic logic [DATA_W:0] alu_f(
      input logic [2:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] k
   );
      logic [DATA_W:0] r;
      case (op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         OP_MOVI: r = {1'b0, k};
         OP_ADDI: r = {1'b0, a} + {1'b0, k};
         OP_CMP:  r = {1'b0, a} - {1'b0, b};
         default: r = {(DATA_W+1){1'b0}};
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;
   logic [ADDR_W-1:0]   reg_a_addr_q, reg_a_addr_d;
   logic [ADDR_W-1:0]   reg_b_addr_q, reg_b_addr_d;
   logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
   logic                reg_we_q, reg_we_d;
   logic                done_q, done_d;
   logic [DATA_W:0]     alu_s;
   logic                accept_s;

   assign accept_s = instr_valid && (state_q == ST_IDLE);
   assign alu_s    = alu_f(op_q, opa_q, opb_q, imm_q);

   // State and datapath registers with synchronous reset; a reset aborts any
   // instruction in flight, so no write and no done follow it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= 3'd0;
         rd_q         <= {ADDR_W{1'b0}};
         imm_q        <= {DATA_W{1'b0}};
         opa_q        <= {DATA_W{1'b0}};
         opb_q        <= {DATA_W{1'b0}};
         result_q     <= {DATA_W{1'b0}};
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
         reg_a_addr_q <= {ADDR_W{1'b0}};
         reg_b_addr_q <= {ADDR_W{1'b0}};
         reg_wdata_q  <= {DATA_W{1'b0}};
         reg_we_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         imm_q        <= imm_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         carry_q      <= carry_d;
         reg_a_addr_q <= reg_a_addr_d;
         reg_b_addr_q <= reg_b_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         reg_we_q     <= reg_we_d;
         done_q       <= done_d;
      end
   end

   // Next-state logic: fixed four-step sequence, leaving IDLE only on accept.
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ:  state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output/datapath logic. The gpreg-facing outputs are registered, so each
   // is loaded one state early with the value the following state presents:
   // source addresses on accept, the write beat at the end of EXEC.
   always_comb begin
      op_d         = op_q;
      rd_d         = rd_q;
      imm_d        = imm_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      result_d     = result_q;
      zero_d       = zero_q;
      carry_d      = carry_q;
      reg_a_addr_d = {ADDR_W{1'b0}};
      reg_b_addr_d = {ADDR_W{1'b0}};
      reg_wdata_d  = {DATA_W{1'b0}};
      reg_we_d     = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d         = opcode;
               rd_d         = rd;
               imm_d        = imm;
               reg_a_addr_d = rs1;
               reg_b_addr_d = rs2;
            end else begin
               reg_a_addr_d = {ADDR_W{1'b0}};
               reg_b_addr_d = {ADDR_W{1'b0}};
            end
         end
         ST_READ: begin
            opa_d = reg_a_data;
            opb_d = reg_b_data;
         end
         ST_EXEC: begin
            result_d     = alu_s[DATA_W-1:0];
            carry_d      = alu_s[DATA_W];
            zero_d       = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
            reg_a_addr_d = rd_q;
            reg_wdata_d  = alu_s[DATA_W-1:0];
            // CMP only updates result and flags; it never writes a register.
            reg_we_d     = (op_q != OP_CMP);
            done_d       = 1'b1;
         end
         ST_WRITE: begin
            done_d = 1'b0;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign reg_a_addr  = reg_a_addr_q;
   assign reg_b_addr  = reg_b_addr_q;
   assign reg_wdata   = reg_wdata_q;
   assign reg_we      = reg_we_q;
   assign result      = result_q;
   assign zero_flag   = zero_q;
   assign carry_flag  = carry_q;
   assign done        = done_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic [7:0] imm;
   logic [4:0] reg_a_addr, reg_b_addr;
   logic [7:0] reg_a_data, reg_b_data;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic [7:0] result;
   logic       zero_flag, carry_flag, done, busy;

   int total = 0;
   int bad   = 0;

   // gpreg stand-in (combinational read, write on rA) and the reference copy
   logic [7:0] regs  [32];
   int         mregs [32];
   int         m_result = 0;
   int         m_zero   = 0;
   int         m_carry  = 0;

   reg_alu_sequencer #(.DATA_W(8), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr),
      .reg_a_data(reg_a_data), .reg_b_data(reg_b_data),
      .reg_wdata(reg_wdata), .reg_we(reg_we),
      .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
      .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reg_we) regs[reg_a_addr] <= reg_wdata;
   end
   assign reg_a_data = regs[reg_a_addr];
   assign reg_b_data = regs[reg_b_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ALU: returns carry*256 + result from the opcode table.
   function automatic int ref_alu(input int op, input int a, input int b, input int k);
      int s;
      int c;
      c = 0;
      case (op)
         0: begin s = a + b; c = (s > 255) ? 1 : 0; end
         1: begin s = a - b; c = (a < b) ? 1 : 0; end
         2: s = a & b;
         3: s = a | b;
         4: s = a ^ b;
         5: s = k;
         6: begin s = a + k; c = (s > 255) ? 1 : 0; end
         default: begin s = a - b; c = (a < b) ? 1 : 0; end
      endcase
      if (s < 0) s = s + 256;
      return c * 256 + (s % 256);
   endfunction

   // Issue one instruction from IDLE and check every cycle of its life.
   task automatic run_instr(input int op, input int d, input int s1, input int s2, input int k);
      int r;
      r = ref_alu(op, mregs[s1], mregs[s2], k);
      chk("ready_idle", instr_ready, 1);
      instr_valid = 1'b1;
      opcode = op[2:0]; rd = d[4:0]; rs1 = s1[4:0]; rs2 = s2[4:0]; imm = k[7:0];
      @(negedge clk);
      instr_valid = 1'b0;
      opcode = 3'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
      chk("read_busy", {busy, instr_ready, reg_we, done}, 4'b1000);
      chk("read_a", reg_a_addr, s1);
      chk("read_b", reg_b_addr, s2);
      @(negedge clk);
      chk("exec_out", {reg_a_addr, reg_b_addr, reg_wdata, reg_we, done}, 0);
      @(negedge clk);
      chk("wr_we", reg_we, (op != 7) ? 1 : 0);
      chk("wr_done", done, 1);
      chk("wr_a", reg_a_addr, d);
      chk("wr_b", reg_b_addr, 0);
      chk("wr_data", reg_wdata, r % 256);
      chk("wr_result", result, r % 256);
      chk("wr_zero", zero_flag, ((r % 256) == 0) ? 1 : 0);
      chk("wr_carry", carry_flag, r / 256);
      m_result = r % 256; m_carry = r / 256; m_zero = (m_result == 0) ? 1 : 0;
      if (op != 7) mregs[d] = m_result;
      @(negedge clk);
      chk("idle_after", {busy, instr_ready, reg_we, done}, 4'b0100);
      chk("regfile", regs[d], mregs[d]);
   endtask

   initial begin
      int dones;
      int wes;
      int r;
      reset = 1'b1; instr_valid = 1'b0;
      opcode = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_status", {instr_ready, busy, reg_we, done}, 4'b1000);
      chk("rst_outs", {reg_a_addr, reg_b_addr, reg_wdata, result, zero_flag, carry_flag}, 0);
      @(negedge clk);
      chk("rst_idle", {instr_ready, busy}, 2'b10);

      // Fill every register through MOVI
      for (int i = 0; i < 32; i++) run_instr(5, i, $urandom_range(0, 31), 0, $urandom_range(0, 255));

      // Directed cases
      run_instr(5, 1, 0, 0, 8'h05);
      run_instr(5, 2, 0, 0, 8'h03);
      run_instr(0, 4, 1, 2, 0);
      run_instr(5, 1, 0, 0, 8'hFF);
      run_instr(5, 2, 0, 0, 8'h01);
      run_instr(0, 5, 1, 2, 0);
      run_instr(1, 6, 2, 1, 0);
      run_instr(5, 1, 0, 0, 8'h10);
      run_instr(5, 2, 0, 0, 8'h10);
      run_instr(7, 9, 1, 2, 0);
      run_instr(5, 31, 0, 0, 8'hA5);
      run_instr(6, 31, 31, 0, 8'h5B);
      run_instr(0, 3, 3, 3, 0);

      // Valid held high through busy: one accept per four cycles
      r = ref_alu(7, mregs[8], mregs[12], 0);
      dones = 0; wes = 0;
      instr_valid = 1'b1; opcode = 3'd7; rd = 5'd8; rs1 = 5'd8; rs2 = 5'd12; imm = 8'd0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (done) dones++;
         if (reg_we) wes++;
      end
      instr_valid = 1'b0;
      chk("hold_dones", dones, 3);
      chk("hold_we", wes, 0);
      chk("hold_result", result, r % 256);
      chk("hold_carry", carry_flag, r / 256);
      @(negedge clk);
      chk("hold_idle", {busy, instr_ready}, 2'b01);

      // Random instruction stream
      for (int i = 0; i < 60; i++)
         run_instr($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 255));

      // Reset during EXEC of ADD rd=7
      instr_valid = 1'b1; opcode = 3'd0; rd = 5'd7; rs1 = 5'd10; rs2 = 5'd11; imm = 8'd0;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_exec", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_status", {busy, instr_ready, reg_we, done}, 4'b0100);
      chk("abort_outs", {reg_a_addr, reg_wdata, result, zero_flag, carry_flag}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_quiet", {reg_we, done, busy}, 0);
      chk("abort_r7", regs[7], mregs[7]);
      run_instr(4, 7, 7, 13, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
